// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM encoding, default sizing and misalignment rule for dmem_responder
package dmem_pkg;

  localparam int DEFAULT_LATENCY     = 2;
  localparam int DEFAULT_DEPTH_WORDS = 256;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_WAIT = S_WAIT,
    ST_RESP = S_RESP
  } dmem_state_e;

  // Full words must be word aligned; half words must be half-word aligned.
  function automatic logic is_misaligned(input logic [1:0] lo, input logic [3:0] be);
    return ((be == 4'b1111) && (lo != 2'b00)) ||
           (((be == 4'b0011) || (be == 4'b1100)) && lo[0]);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with byte-lane synchronous write and combinational read
module dmem_array #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [WIDTH-1:0]               wdata,
  input  logic [WIDTH/8-1:0]             be,
  output logic [WIDTH-1:0]               rdata
);

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  // Contents survive reset by design; only the enabled lanes are touched.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WIDTH/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder; DMEM_MISALIGN_ERR_EN enables misalignment errors
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_be,
  output logic               rsp_valid,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               stall
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  dmem_state_e      state;
  logic [3:0]       cnt;
  logic             cap_we;
  logic [AW-1:0]    cap_idx;
  logic [WIDTH-1:0] cap_wdata;
  logic [WIDTH/8-1:0] cap_be;
  logic [WIDTH-1:0] rd_word;
  logic             mis;

`ifdef DMEM_MISALIGN_ERR_EN
  logic [1:0] cap_lo;
  logic       unused_addr;
  assign unused_addr = ^req_addr[WIDTH-1:AW+2];
  assign mis         = is_misaligned(cap_lo, cap_be[3:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cap_lo <= 2'b00;
    else if (state == ST_IDLE && req_valid) cap_lo <= req_addr[1:0];
  end
`else
  logic unused_addr;
  assign unused_addr = ^{req_addr[WIDTH-1:AW+2], req_addr[1:0]};
  assign mis         = 1'b0;
`endif

  // The request is captured on accept so later input changes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cap_we    <= req_we;
            cap_idx   <= req_addr[AW+1:2];
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  dmem_array #(
    .WIDTH       (WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (state == ST_RESP && cap_we && !mis),
    .addr  (cap_idx),
    .wdata (cap_wdata),
    .be    (cap_be),
    .rdata (rd_word)
  );

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = (state == ST_RESP) && mis;
  assign rsp_rdata = (state == ST_RESP && !mis) ? (cap_we ? cap_wdata : rd_word) : '0;
  assign stall     = ((state == ST_IDLE) && req_valid) || (state == ST_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed table-driven bench for dmem_responder (LATENCY 2 and 3 instances)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_a, valid_b, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        ready_a, rvalid_a, err_a, stall_a;
  logic [31:0] rdata_a;
  logic        ready_b, rvalid_b, err_b, stall_b;
  logic [31:0] rdata_b;

  logic        sel;
  logic        ready_m, rvalid_m, err_m, stall_m;
  logic [31:0] rdata_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WIDTH(32), .DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rvalid_a),
    .rsp_rdata(rdata_a), .rsp_err(err_a), .stall(stall_a)
  );

  dmem_responder #(.WIDTH(32), .DEPTH_WORDS(256), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rvalid_b),
    .rsp_rdata(rdata_b), .rsp_err(err_b), .stall(stall_b)
  );

  assign ready_m  = sel ? ready_b  : ready_a;
  assign rvalid_m = sel ? rvalid_b : rvalid_a;
  assign err_m    = sel ? err_b    : err_a;
  assign stall_m  = sel ? stall_b  : stall_a;
  assign rdata_m  = sel ? rdata_b  : rdata_a;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after RESP.
  task automatic do_req(input logic s, input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int exp_lat,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int   lat;
    logic got;
    sel = s; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    if (s) valid_b = 1'b1; else valid_a = 1'b1;
    #1;
    chk({name, ".ready"}, 32'(ready_m), 32'd1);
    chk({name, ".stall_acc"}, 32'(stall_m), 32'd1);
    @(posedge clk); #1;
    valid_a = 1'b0; valid_b = 1'b0;
    req_we = ~we; req_addr = addr ^ 32'h4; req_wdata = ~wdata; req_be = ~be;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rvalid_m) got = 1'b1;
      else begin
        chk({name, ".stall_wait"}, 32'(stall_m), 32'd1);
        chk({name, ".rdata_idle"}, rdata_m, 32'd0);
      end
    end
    chk({name, ".rsp_seen"}, 32'(got), 32'd1);
    chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({name, ".rdata"}, rdata_m, exp_rdata);
    chk({name, ".err"}, 32'(err_m), 32'(exp_err));
    chk({name, ".stall_resp"}, 32'(stall_m), 32'd0);
    @(negedge clk);
    chk({name, ".rsp_pulse"}, 32'(rvalid_m), 32'd0);
    chk({name, ".ready_after"}, 32'(ready_m), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{"st_full",  1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{"ld_full",  1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{"st_pre",   1'b1, 32'h20,  32'h11223344, 4'hF, 32'h11223344, 1'b0};
    vecs[3]  = '{"st_lanes", 1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'hAABBCCDD, 1'b0};
    vecs[4]  = '{"ld_lanes", 1'b0, 32'h20,  32'h0,        4'hF, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{"st_wrap",  1'b1, 32'h400, 32'h5,        4'hF, 32'h5,        1'b0};
    vecs[6]  = '{"ld_wrap",  1'b0, 32'h0,   32'h0,        4'hF, 32'h5,        1'b0};
    vecs[7]  = '{"st_be0p",  1'b1, 32'h30,  32'h12345678, 4'hF, 32'h12345678, 1'b0};
    vecs[8]  = '{"st_be0",   1'b1, 32'h30,  32'hFFFFFFFF, 4'h0, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{"ld_be0",   1'b0, 32'h30,  32'h0,        4'hF, 32'h12345678, 1'b0};
    vecs[10] = '{"st_last",  1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 32'h0BADF00D, 1'b0};
`ifdef DMEM_MISALIGN_ERR_EN
    vecs[11] = '{"ld_mis",   1'b0, 32'h2,   32'h0,        4'hF, 32'h0,        1'b1};
`else
    vecs[11] = '{"ld_mis",   1'b0, 32'h2,   32'h0,        4'hF, 32'h5,        1'b0};
`endif

    sel = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.rsp_valid", 32'(rvalid_a), 32'd0);
    chk("rst.rdata", rdata_a, 32'd0);
    chk("rst.err", 32'(err_a), 32'd0);
    chk("rst.stall", 32'(stall_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(ready_a), 32'd1);

    // Each request starts in the IDLE cycle right after the previous RESP.
    for (int i = 0; i < 12; i++)
      do_req(1'b0, vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 2,
             vecs[i].exp_rdata, vecs[i].exp_err);
    do_req(1'b0, "ld_last", 1'b0, 32'h3FC, 32'h0, 4'hF, 2, 32'h0BADF00D, 1'b0);

    // Reset during WAIT must discard the pending store.
    do_req(1'b0, "st_old", 1'b1, 32'h8, 32'h7, 4'hF, 2, 32'h7, 1'b0);
    sel = 1'b0; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h1; req_be = 4'hF; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    @(negedge clk);
    chk("rmid.stall_wait", 32'(stall_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmid.rsp_valid", 32'(rvalid_a), 32'd0);
    chk("rmid.stall", 32'(stall_a), 32'd0);
    chk("rmid.ready", 32'(ready_a), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rmid.no_rsp", 32'(rvalid_a), 32'd0);
    end
    do_req(1'b0, "rmid.ld", 1'b0, 32'h8, 32'h0, 4'hF, 2, 32'h7, 1'b0);

    // LATENCY=3 instance: stall through accept and two WAIT cycles.
    do_req(1'b1, "l3.st", 1'b1, 32'h0, 32'hCAFE0001, 4'hF, 3, 32'hCAFE0001, 1'b0);
    do_req(1'b1, "l3.ld", 1'b0, 32'h0, 32'h0, 4'hF, 3, 32'hCAFE0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
